fb_reader: RTL and testbench

//  Wishbone read master that streams the framebuffer out of SDRAM, pixel by pixel, raster order.

---
 rtl/fb_reader_if.sv | 32 +++
 rtl/fb_reader.sv | 197 +++++++++++++++++++
 tb/tb_fb_reader.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_reader_if.sv
// Bus bundle for fb_reader: Wishbone read channel toward SDRAM plus the
// valid/ready pixel stream toward the VGA output stage.
// master = the framebuffer reader, slave = memory side plus pixel consumer.
interface fb_reader_if;
    logic [31:0] wshb_adr;
    logic        wshb_cyc;
    logic        wshb_stb;
    logic        wshb_we;
    logic [1:0]  wshb_sel;
    logic [2:0]  wshb_cti;
    logic [1:0]  wshb_bte;
    logic [15:0] wshb_dat_sm;
    logic        wshb_ack;
    logic [15:0] pix_data;
    logic        pix_sof;
    logic        pix_valid;
    logic        pix_ready;

    modport master (
        output wshb_adr, wshb_cyc, wshb_stb, wshb_we, wshb_sel, wshb_cti, wshb_bte,
        input  wshb_dat_sm, wshb_ack,
        output pix_data, pix_sof, pix_valid,
        input  pix_ready
    );

    modport slave (
        input  wshb_adr, wshb_cyc, wshb_stb, wshb_we, wshb_sel, wshb_cti, wshb_bte,
        output wshb_dat_sm, wshb_ack,
        input  pix_data, pix_sof, pix_valid,
        output pix_ready
    );
endinterface

// File: rtl/fb_reader.sv
// fb_reader: Wishbone read master that streams the framebuffer out of SDRAM
// in raster order into a first-word-fall-through pixel FIFO.
// Optional feature: define FB_READER_UNDERFLOW_EN to add the 16-bit
// saturating underflow_cnt output (consumer ready while FIFO empty).
//
// state | meaning
// IDLE  | no bus request; waits for a free FIFO slot
// REQ   | cyc/stb high on the current pixel address, waiting for ack
// PAUSE | bus released for GAP cycles after MAX_BURST reads
module fb_reader #(
    parameter int HDISP      = 640,
    parameter int VDISP      = 480,
    parameter int FIFO_DEPTH = 256,
    parameter int MAX_BURST  = 64,
    parameter int GAP        = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FB_READER_UNDERFLOW_EN
    output logic [15:0] underflow_cnt,
`endif
    fb_reader_if.master bus
);

    localparam int XW = $clog2(HDISP);
    localparam int YW = $clog2(VDISP);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [31:0]   adr;
    logic [BW-1:0] burst_cnt;
    logic [GW-1:0] gap_cnt;
    logic [16:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          push;
    logic          pop;
    logic          pix_valid;
    logic          last_in_burst;
    logic          gap_done;
    logic          frame_start;

    // Acks seen outside REQ are stale and never reach the FIFO.
    assign push          = (state == REQ) && bus.wshb_ack;
    assign pix_valid     = (count != '0);
    assign pop           = pix_valid && bus.pix_ready;
    assign last_in_burst = (burst_cnt == BW'(MAX_BURST - 1));
    assign gap_done      = (gap_cnt == GW'(GAP - 1));
    assign frame_start   = (x == '0) && (y == '0);

    // FIFO occupancy after this cycle's push/pop, used for the REQ decision.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (!push && pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; a request is only launched while a FIFO slot is free,
    // and the count cannot grow during REQ, so the pending ack always fits.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (count < CW'(FIFO_DEPTH)) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (push) begin
                    if (last_in_burst) begin
                        state_nxt = PAUSE;
                    end else if (count_nxt < CW'(FIFO_DEPTH)) begin
                        state_nxt = REQ;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            PAUSE: begin
                // Leave straight into REQ so the bus sees exactly GAP idle cycles.
                if (gap_done) begin
                    state_nxt = (count < CW'(FIFO_DEPTH)) ? REQ : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: classic single-cycle read, fixed bus attributes.
    always_comb begin
        bus.wshb_cyc = (state == REQ);
        bus.wshb_stb = (state == REQ);
        bus.wshb_adr = adr;
        bus.wshb_we  = 1'b0;
        bus.wshb_sel = 2'b11;
        bus.wshb_cti = 3'b000;
        bus.wshb_bte = 2'b00;
    end

    // Raster walk, byte address, burst and pause counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            adr       <= '0;
            burst_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            if (push) begin
                if (x == XW'(HDISP - 1)) begin
                    x <= '0;
                    if (y == YW'(VDISP - 1)) begin
                        y   <= '0;
                        adr <= '0;
                    end else begin
                        y   <= y + YW'(1);
                        adr <= adr + 32'd2;
                    end
                end else begin
                    x   <= x + XW'(1);
                    adr <= adr + 32'd2;
                end
                burst_cnt <= last_in_burst ? '0 : burst_cnt + BW'(1);
            end
            gap_cnt <= (state == PAUSE) ? gap_cnt + GW'(1) : '0;
        end
    end

    // FIFO storage: {sof, pixel}; contents need no reset since count gates them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {frame_start, bus.wshb_dat_sm};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_nxt;
        end
    end

    // First-word-fall-through head; outputs read zero while empty.
    always_comb begin
        bus.pix_valid = pix_valid;
        bus.pix_data  = pix_valid ? mem[rd_ptr][15:0] : 16'h0000;
        bus.pix_sof   = pix_valid && mem[rd_ptr][16];
    end

`ifdef FB_READER_UNDERFLOW_EN
    // Count cycles the consumer wanted a pixel and none was there; saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow_cnt <= 16'h0000;
        end else if (bus.pix_ready && !pix_valid && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fb_reader.sv
// Directed testbench for fb_reader with a small frame (40x12) so a full
// frame wrap fits in a short run; FIFO, burst and gap sizes are the defaults.
module tb_fb_reader;
    localparam int HDISP      = 40;
    localparam int VDISP      = 12;
    localparam int FRAME      = HDISP * VDISP;
    localparam int FIFO_DEPTH = 256;
    localparam int MAX_BURST  = 64;
    localparam int GAP        = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        slave_ack = 1'b0;
    logic        stale_ack = 1'b0;
    logic        slave_en = 1'b1;
    logic [15:0] slave_dat = 16'h0000;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          ack_count = 0;
    int          checks = 0;
    int          errors = 0;
`ifdef FB_READER_UNDERFLOW_EN
    logic [15:0] underflow_cnt;
`endif

    fb_reader_if bus ();

    assign bus.wshb_ack    = slave_ack | stale_ack;
    assign bus.wshb_dat_sm = slave_dat;

    fb_reader #(
        .HDISP(HDISP), .VDISP(VDISP), .FIFO_DEPTH(FIFO_DEPTH),
        .MAX_BURST(MAX_BURST), .GAP(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef FB_READER_UNDERFLOW_EN
        .underflow_cnt(underflow_cnt),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pix_model(input int idx);
        logic [15:0] v;
        v = 16'(idx * 37);
        return v ^ 16'hA5A5;
    endfunction

    // Memory slave: acks each request ack_delay+1 edges after stb is seen.
    always @(posedge clk) begin
        if (rst || !(bus.wshb_cyc && bus.wshb_stb) || slave_ack) begin
            slave_ack <= 1'b0;
            wait_cnt  <= 0;
        end else if (slave_en) begin
            if (wait_cnt >= ack_delay) begin
                slave_ack <= 1'b1;
                slave_dat <= pix_model(int'(bus.wshb_adr[31:1]));
                ack_count <= ack_count + 1;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.pix_ready = 1'b0;
        slave_en = 1'b1;
        ack_delay = 0;
        stale_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pix_ready = 1'b1;
        slave_en = 1'b1;
        ack_delay = 0;
        stale_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.wshb_cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b expected 0", bus.wshb_cyc); end
        checks++; if (bus.wshb_stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", bus.wshb_stb); end
        checks++; if (bus.wshb_adr !== 32'd0) begin errors++; $display("FAIL reset_adr: got %0h expected 0", bus.wshb_adr); end
        checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.pix_valid); end
        checks++; if (bus.pix_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", bus.pix_data); end
        checks++; if (bus.pix_sof !== 1'b0) begin errors++; $display("FAIL reset_sof: got %b expected 0", bus.pix_sof); end
        checks++;
        if ({bus.wshb_we, bus.wshb_sel, bus.wshb_cti, bus.wshb_bte} !== 8'b0_11_000_00) begin
            errors++;
            $display("FAIL reset_attr: got we=%b sel=%b cti=%b bte=%b expected 0/11/000/00",
                     bus.wshb_we, bus.wshb_sel, bus.wshb_cti, bus.wshb_bte);
        end
`ifdef FB_READER_UNDERFLOW_EN
        checks++; if (underflow_cnt !== 16'd0) begin errors++; $display("FAIL reset_underflow: got %0d expected 0", underflow_cnt); end
`endif
    endtask

    task automatic test_stream();
        int nack = 0;
        int npop = 0;
        int gap = 0;
        bit after_burst = 0;
        bit gap_checked = 0;
        bit acked;
        do_reset();
        bus.pix_ready = 1'b1;
        for (int c = 0; c < 1000 && nack < 130; c++) begin
            acked = 0;
            if (bus.wshb_cyc && bus.wshb_stb && bus.wshb_ack) begin
                acked = 1;
                checks++;
                if (bus.wshb_adr !== 32'(2 * nack)) begin
                    errors++; $display("FAIL stream_adr: ack %0d got %0h expected %0h", nack, bus.wshb_adr, 2 * nack);
                end
                nack++;
                if (nack == MAX_BURST) after_burst = 1;
            end
            if (after_burst && !gap_checked && !acked) begin
                if (!bus.wshb_cyc) gap++;
                else begin
                    checks++; gap_checked = 1;
                    if (gap != GAP) begin errors++; $display("FAIL stream_gap: got %0d idle cycles expected %0d", gap, GAP); end
                end
            end
            if (bus.pix_valid && bus.pix_ready) begin
                checks++;
                if (bus.pix_data !== pix_model(npop) || bus.pix_sof !== (npop == 0)) begin
                    errors++; $display("FAIL stream_pix: pixel %0d got %h/%b expected %h/%b",
                                       npop, bus.pix_data, bus.pix_sof, pix_model(npop), npop == 0);
                end
                npop++;
            end
            @(negedge clk);
        end
        checks++; if (nack < 130) begin errors++; $display("FAIL stream_timeout: got %0d acks expected 130", nack); end
        checks++; if (!gap_checked) begin errors++; $display("FAIL stream_gap_seen: got no bus return expected return after %0d idle", GAP); end
    endtask

    task automatic test_fill();
        int start;
        int npop = 0;
        do_reset();
        start = ack_count;
        repeat (1200) @(negedge clk);
        checks++; if (ack_count - start != FIFO_DEPTH) begin errors++; $display("FAIL fill_acks: got %0d expected %0d", ack_count - start, FIFO_DEPTH); end
        checks++; if (bus.wshb_cyc !== 1'b0) begin errors++; $display("FAIL fill_cyc: got %b expected 0", bus.wshb_cyc); end
        checks++; if (bus.pix_valid !== 1'b1) begin errors++; $display("FAIL fill_valid: got %b expected 1", bus.pix_valid); end
        repeat (20) @(negedge clk);
        checks++; if (ack_count - start != FIFO_DEPTH) begin errors++; $display("FAIL fill_hold_acks: got %0d expected %0d", ack_count - start, FIFO_DEPTH); end
        checks++; if (bus.wshb_cyc !== 1'b0) begin errors++; $display("FAIL fill_hold_cyc: got %b expected 0", bus.wshb_cyc); end
        checks++;
        if (bus.pix_data !== pix_model(0) || bus.pix_sof !== 1'b1) begin
            errors++; $display("FAIL fill_hold_data: got %h/%b expected %h/1", bus.pix_data, bus.pix_sof, pix_model(0));
        end
        bus.pix_ready = 1'b1;
        for (int c = 0; c < 2000 && npop < 300; c++) begin
            if (bus.pix_valid && bus.pix_ready) begin
                checks++;
                if (bus.pix_data !== pix_model(npop % FRAME) || bus.pix_sof !== (npop % FRAME == 0)) begin
                    errors++; $display("FAIL drain_pix: pixel %0d got %h/%b expected %h/%b",
                                       npop, bus.pix_data, bus.pix_sof, pix_model(npop % FRAME), npop % FRAME == 0);
                end
                npop++;
            end
            @(negedge clk);
        end
        checks++; if (npop < 300) begin errors++; $display("FAIL drain_timeout: got %0d pixels expected 300", npop); end
    endtask

    task automatic test_frame_wrap();
        int nack = 0;
        int npop = 0;
        do_reset();
        bus.pix_ready = 1'b1;
        for (int c = 0; c < 3000 && npop < FRAME + 20; c++) begin
            if (bus.wshb_cyc && bus.wshb_stb && bus.wshb_ack) begin
                checks++;
                if (bus.wshb_adr !== 32'(2 * (nack % FRAME))) begin
                    errors++; $display("FAIL wrap_adr: ack %0d got %0h expected %0h", nack, bus.wshb_adr, 2 * (nack % FRAME));
                end
                nack++;
            end
            if (bus.pix_valid && bus.pix_ready) begin
                checks++;
                if (bus.pix_data !== pix_model(npop % FRAME) || bus.pix_sof !== (npop % FRAME == 0)) begin
                    errors++; $display("FAIL wrap_pix: pixel %0d got %h/%b expected %h/%b",
                                       npop, bus.pix_data, bus.pix_sof, pix_model(npop % FRAME), npop % FRAME == 0);
                end
                npop++;
            end
            @(negedge clk);
        end
        checks++; if (npop < FRAME + 20) begin errors++; $display("FAIL wrap_timeout: got %0d pixels expected %0d", npop, FRAME + 20); end
    endtask

    task automatic test_slow_ack();
        int nack = 0;
        int npop = 0;
        bit holding = 0;
        logic [31:0] held = '0;
        do_reset();
        ack_delay = 5;
        bus.pix_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (bus.wshb_cyc && bus.wshb_stb) begin
                if (!holding) begin
                    held = bus.wshb_adr;
                    holding = 1;
                end else begin
                    checks++;
                    if (bus.wshb_adr !== held) begin errors++; $display("FAIL slow_adr_stable: got %0h expected %0h", bus.wshb_adr, held); end
                end
                if (bus.wshb_ack) begin
                    checks++;
                    if (bus.wshb_adr !== 32'(2 * nack)) begin errors++; $display("FAIL slow_adr: ack %0d got %0h expected %0h", nack, bus.wshb_adr, 2 * nack); end
                    nack++;
                    holding = 0;
                end
            end else begin
                holding = 0;
            end
            if (bus.pix_valid && bus.pix_ready) begin
                checks++;
                if (bus.pix_data !== pix_model(npop)) begin
                    errors++; $display("FAIL slow_pix: pixel %0d got %h expected %h", npop, bus.pix_data, pix_model(npop));
                end
                npop++;
            end
            if (nack == 6) slave_en = 1'b0;
            @(negedge clk);
        end
        checks++; if (nack != 6) begin errors++; $display("FAIL slow_acks: got %0d expected 6", nack); end
        checks++; if (npop != 6) begin errors++; $display("FAIL slow_pixels: got %0d expected 6", npop); end
    endtask

    task automatic test_reset_mid();
        int start;
        int c;
        bit popped = 0;
        do_reset();
        start = ack_count;
        c = 0;
        while (ack_count - start < 10 && c < 200) begin @(negedge clk); c++; end
        checks++; if (ack_count - start != 10) begin errors++; $display("FAIL mid_fill: got %0d acks expected 10", ack_count - start); end
        ack_delay = 5;
        @(negedge clk);
        c = 0;
        while (!(bus.wshb_cyc && bus.wshb_stb) && c < 20) begin @(negedge clk); c++; end
        checks++; if (bus.wshb_stb !== 1'b1) begin errors++; $display("FAIL mid_stb_before: got %b expected 1", bus.wshb_stb); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.wshb_cyc !== 1'b0) begin errors++; $display("FAIL mid_cyc: got %b expected 0", bus.wshb_cyc); end
        checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", bus.pix_valid); end
        slave_en = 1'b0;
        stale_ack = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        stale_ack = 1'b0;
        checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_ack: got valid %b expected 0", bus.pix_valid); end
        checks++; if (bus.wshb_cyc !== 1'b1) begin errors++; $display("FAIL mid_restart_cyc: got %b expected 1", bus.wshb_cyc); end
        checks++; if (bus.wshb_adr !== 32'd0) begin errors++; $display("FAIL mid_restart_adr: got %0h expected 0", bus.wshb_adr); end
        slave_en = 1'b1;
        ack_delay = 0;
        bus.pix_ready = 1'b1;
        for (int k = 0; k < 50 && !popped; k++) begin
            if (bus.pix_valid) begin
                popped = 1;
                checks++;
                if (bus.pix_data !== pix_model(0) || bus.pix_sof !== 1'b1) begin
                    errors++; $display("FAIL mid_first_pix: got %h/%b expected %h/1", bus.pix_data, bus.pix_sof, pix_model(0));
                end
            end
            @(negedge clk);
        end
        checks++; if (!popped) begin errors++; $display("FAIL mid_timeout: got no pixel expected one within 50 cycles"); end
    endtask

`ifdef FB_READER_UNDERFLOW_EN
    task automatic test_underflow();
        rst = 1'b1;
        bus.pix_ready = 1'b1;
        slave_en = 1'b0;
        stale_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (underflow_cnt !== 16'd0) begin errors++; $display("FAIL underflow_reset: got %0d expected 0", underflow_cnt); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (underflow_cnt !== 16'd20) begin errors++; $display("FAIL underflow_count: got %0d expected 20", underflow_cnt); end
        slave_en = 1'b1;
    endtask
`endif

    initial begin
        bus.pix_ready = 1'b0;
        test_reset();
        test_stream();
        test_fill();
        test_frame_wrap();
        test_slow_ack();
        test_reset_mid();
`ifdef FB_READER_UNDERFLOW_EN
        test_underflow();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
